// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcode and FSM state
// enumerations, instruction field positions and opcode classification.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SRA  = 4'h8,
    OP_MUL  = 4'h9,
    OP_LDI  = 4'hA,
    OP_BEQZ = 4'hB,
    OP_JMP  = 4'hC,
    OP_NOPD = 4'hD,
    OP_NOPE = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXECUTE,
    ST_COP_WAIT,
    ST_WRITEBACK,
    ST_HALTED
  } state_e;

  // Instruction field positions
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 8;
  localparam int RS1_MSB   = 7;
  localparam int RS1_LSB   = 4;
  localparam int RS2_MSB   = 3;
  localparam int RS2_LSB   = 0;
  localparam int IMM8_MSB  = 7;
  localparam int IMM12_MSB = 11;

  // Every opcode up to and including LDI produces a register result.
  function automatic logic writes_rd(input opcode_e op);
    return (op <= OP_LDI);
  endfunction

  function automatic logic uses_cop(input opcode_e op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for all locally executed arithmetic/logic opcodes.
// Ports: op (opcode), a/b (operands), result (DATA_W-bit result).
// Opcodes not handled here yield zero.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: result = a << sh;
      OP_SRL: result = a >> sh;
      OP_SRA: result = $signed(a) >>> sh;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_multiciclo_param.sv
// Parametrised multi-cycle processor core with 16-entry register file.
// Ports: clock/reset (async active-high); imem_en/imem_addr/imem_rdata
// instruction fetch; cop_req/op/a/b/ack/result coprocessor handshake;
// halted, cop_error (sticky timeout), pc, retired status; dbg_raddr/
// dbg_rdata combinational register-file peek.
module cpu_multiciclo_param
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 16,
  parameter int IMEM_AW     = 8,
  parameter int IMEM_LAT    = 1,
  parameter int COP_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic               cop_req,
  output logic [3:0]         cop_op,
  output logic [DATA_W-1:0]  cop_a,
  output logic [DATA_W-1:0]  cop_b,
  input  logic               cop_ack,
  input  logic [DATA_W-1:0]  cop_result,
  output logic               halted,
  output logic               cop_error,
  output logic [PC_W-1:0]    pc,
  output logic [31:0]        retired,
  input  logic [3:0]         dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  localparam int CNT_W = 16;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rdv_q, rdv_d, res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cop_req_q, cop_req_d, cop_error_q, cop_error_d;
  logic [3:0]        cop_op_q, cop_op_d;
  logic [DATA_W-1:0] cop_a_q, cop_a_d, cop_b_q, cop_b_d;
  logic [31:0]       retired_q, retired_d;

  logic [DATA_W-1:0] regs_q [16];
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  opcode_e           op;
  logic [3:0]        rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0] alu_result;

  assign op      = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign rd_idx  = ir_q[RD_MSB:RD_LSB];
  assign rs1_idx = ir_q[RS1_MSB:RS1_LSB];
  assign rs2_idx = ir_q[RS2_MSB:RS2_LSB];

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    return (idx == 4'd0) ? '0 : regs_q[idx];
  endfunction

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    rdv_d       = rdv_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    cop_req_d   = cop_req_q;
    cop_op_d    = cop_op_q;
    cop_a_d     = cop_a_q;
    cop_b_d     = cop_b_q;
    cop_error_d = cop_error_q;
    retired_d   = retired_q;
    rf_we       = 1'b0;
    rf_waddr    = rd_idx;
    rf_wdata    = res_q;

    case (state_q)
      ST_FETCH: begin
        cnt_d   = '0;
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        if (cnt_q == CNT_W'(IMEM_LAT - 1)) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        a_d     = rf_read(rs1_idx);
        b_d     = rf_read(rs2_idx);
        rdv_d   = rf_read(rd_idx);
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (uses_cop(op)) begin
          // Operands are latched here and held for the whole handshake.
          cop_req_d = 1'b1;
          cop_op_d  = op;
          cop_a_d   = a_q;
          cop_b_d   = b_q;
          cnt_d     = '0;
          state_d   = ST_COP_WAIT;
        end else begin
          res_d   = (op == OP_LDI) ? DATA_W'($signed(ir_q[IMM8_MSB:0])) : alu_result;
          state_d = ST_WRITEBACK;
        end
      end
      ST_COP_WAIT: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (cop_ack) begin
          res_d     = cop_result;
          cop_req_d = 1'b0;
          state_d   = ST_WRITEBACK;
        end else if (cnt_q == CNT_W'(COP_TIMEOUT - 1)) begin
          res_d       = '0;
          cop_error_d = 1'b1;
          cop_req_d   = 1'b0;
          state_d     = ST_WRITEBACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITEBACK: begin
        retired_d = retired_q + 32'd1;
        rf_we     = writes_rd(op) && (rd_idx != 4'd0);
        state_d   = ST_FETCH;
        case (op)
          OP_BEQZ: pc_d = (rdv_q == '0)
                          ? pc_q + PC_W'(1) + PC_W'($signed(ir_q[IMM8_MSB:0]))
                          : pc_q + PC_W'(1);
          OP_JMP:  pc_d = PC_W'(ir_q[IMM12_MSB:0]);
          OP_HALT: state_d = ST_HALTED;
          default: pc_d = pc_q + PC_W'(1);
        endcase
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rdv_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      cop_req_q   <= 1'b0;
      cop_op_q    <= '0;
      cop_a_q     <= '0;
      cop_b_q     <= '0;
      cop_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rdv_q       <= rdv_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      cop_req_q   <= cop_req_d;
      cop_op_q    <= cop_op_d;
      cop_a_q     <= cop_a_d;
      cop_b_q     <= cop_b_d;
      cop_error_q <= cop_error_d;
      retired_q   <= retired_d;
    end
  end

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Gated by reset so the strobe is low while reset is held, even though
  // the FSM already sits in FETCH.
  assign imem_en   = (state_q == ST_FETCH) && !reset;
  assign imem_addr = pc_q[IMEM_AW-1:0];
  assign cop_req   = cop_req_q;
  assign cop_op    = cop_op_q;
  assign cop_a     = cop_a_q;
  assign cop_b     = cop_b_q;
  assign halted    = (state_q == ST_HALTED);
  assign cop_error = cop_error_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign dbg_rdata = rf_read(dbg_raddr);

endmodule

// File: tb/tb_cpu_multiciclo_param.sv
module tb_cpu_multiciclo_param;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        rst1 = 1'b1, rst3 = 1'b1;
  logic [3:0]  dbg_raddr = 4'd0;
  logic [15:0] mem [256];

  logic        imem_en1, imem_en3;
  logic [7:0]  imem_addr1, imem_addr3, maddr1_q = 8'd0, maddr3_q = 8'd0;
  logic [15:0] imem_rdata1, imem_rdata3;
  logic        cop_req1, cop_req3, cop_ack1;
  logic [3:0]  cop_op1, cop_op3;
  logic [31:0] cop_a1, cop_b1, cop_a3, cop_b3, cop_result1;
  logic        halted1, halted3, cop_error1, cop_error3;
  logic [15:0] pc1, pc3;
  logic [31:0] retired1, retired3, dbg_rdata1, dbg_rdata3;

  int checks = 0;
  int failures = 0;
  int slave_delay = 0;
  int req_cnt = 0;
  int last_len = 0;
  int cyc = 0;
  bit prev_en3 = 0;
  bit wide3 = 0;
  int fetch_cyc[$];
  logic [7:0] fetch_addr[$];

  cpu_multiciclo_param #(.IMEM_LAT(1), .COP_TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(rst1), .imem_en(imem_en1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .cop_req(cop_req1), .cop_op(cop_op1),
    .cop_a(cop_a1), .cop_b(cop_b1), .cop_ack(cop_ack1), .cop_result(cop_result1),
    .halted(halted1), .cop_error(cop_error1), .pc(pc1), .retired(retired1),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata1)
  );

  cpu_multiciclo_param #(.IMEM_LAT(3), .COP_TIMEOUT(TMO)) u_dut3 (
    .clock(clock), .reset(rst3), .imem_en(imem_en3), .imem_addr(imem_addr3),
    .imem_rdata(imem_rdata3), .cop_req(cop_req3), .cop_op(cop_op3),
    .cop_a(cop_a3), .cop_b(cop_b3), .cop_ack(1'b0), .cop_result(32'd0),
    .halted(halted3), .cop_error(cop_error3), .pc(pc3), .retired(retired3),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata3)
  );

  always #5 clock = ~clock;

  // Instruction memory: address captured on the fetch strobe, data held after.
  always @(posedge clock) begin
    if (imem_en1) maddr1_q <= imem_addr1;
    if (imem_en3) maddr3_q <= imem_addr3;
    cyc <= cyc + 1;
  end
  assign imem_rdata1 = mem[maddr1_q];
  assign imem_rdata3 = mem[maddr3_q];

  // Coprocessor slave: acks during the slave_delay-th cycle of cop_req high
  // (never when slave_delay is 0) with the product of its operands.
  always @(posedge clock) begin
    req_cnt <= cop_req1 ? req_cnt + 1 : 0;
    if (cop_req1) last_len <= req_cnt + 1;
  end
  assign cop_ack1    = cop_req1 && (slave_delay != 0) && (req_cnt == slave_delay - 1);
  assign cop_result1 = cop_a1 * cop_b1;

  always @(negedge clock) begin
    if (imem_en3) begin
      fetch_cyc.push_back(cyc);
      fetch_addr.push_back(imem_addr3);
      if (prev_en3) wide3 <= 1'b1;
    end
    prev_en3 <= imem_en3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ISA-level reference: executes the program in mem instruction by instruction.
  logic [31:0] m_r [16];
  logic [15:0] m_pc;
  int          m_ret, m_cyc;
  bit          m_err;

  task automatic model_run(input int lat, input int dly);
    logic [15:0] ins;
    logic [3:0]  op, rd;
    logic [31:0] a, b, res;
    int          k;
    bit          done;
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_pc = 16'd0; m_ret = 0; m_cyc = 0; m_err = 0; done = 0;
    for (int s = 0; s < 500 && !done; s++) begin
      ins = mem[m_pc[7:0]];
      op  = ins[15:12];
      rd  = ins[11:8];
      a   = m_r[ins[7:4]];
      b   = m_r[ins[3:0]];
      res = 32'd0;
      k   = 0;
      case (op)
        4'h0: res = a + b;
        4'h1: res = a - b;
        4'h2: res = a & b;
        4'h3: res = a | b;
        4'h4: res = a ^ b;
        4'h5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'h6: res = a << b[4:0];
        4'h7: res = a >> b[4:0];
        4'h8: res = $signed(a) >>> b[4:0];
        4'h9: if (dly >= 1 && dly <= TMO) begin res = a * b; k = dly; end
              else begin res = 32'd0; k = TMO; m_err = 1; end
        4'hA: res = {{24{ins[7]}}, ins[7:0]};
        default: ;
      endcase
      m_cyc += 4 + lat + k;
      m_ret++;
      if (op == 4'hB)      m_pc = (m_r[rd] == 32'd0) ? m_pc + 16'd1 + {{8{ins[7]}}, ins[7:0]} : m_pc + 16'd1;
      else if (op == 4'hC) m_pc = {4'd0, ins[11:0]};
      else if (op == 4'hF) done = 1;
      else                 m_pc = m_pc + 16'd1;
      if (op <= 4'hA && rd != 4'd0) m_r[rd] = res;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic gen_random(input bit with_mul);
    int r;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = {4'hA, 4'(i + 1), 8'($urandom)};
    for (int i = 4; i < 16; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 8)       mem[i] = {4'(r), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      else if (r == 9)  mem[i] = {(with_mul ? 4'h9 : 4'h0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      else if (r == 10) mem[i] = {4'hB, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 3))};
      else              mem[i] = {4'hD, 12'($urandom)};
    end
  endtask

  task automatic run_prog(input bit use3, input int dly, input string tag);
    int lat;
    int n;
    bit done;
    lat = use3 ? 3 : 1;
    slave_delay = dly;
    model_run(lat, dly);
    @(negedge clock);
    if (use3) rst3 = 1'b1; else rst1 = 1'b1;
    #1;
    chk({tag, " rst imem_en"}, use3 ? imem_en3 : imem_en1, 0);
    chk({tag, " rst cop_req"}, use3 ? cop_req3 : cop_req1, 0);
    chk({tag, " rst cop_a"},   use3 ? cop_a3 : cop_a1, 0);
    chk({tag, " rst pc"},      use3 ? pc3 : pc1, 0);
    chk({tag, " rst retired"}, use3 ? retired3 : retired1, 0);
    chk({tag, " rst halted"},  use3 ? halted3 : halted1, 0);
    @(negedge clock);
    if (use3) rst3 = 1'b0; else rst1 = 1'b0;
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
      done = use3 ? halted3 : halted1;
    end
    chk({tag, " halted"},    done, 1);
    chk({tag, " cycles"},    n, m_cyc);
    chk({tag, " retired"},   use3 ? retired3 : retired1, m_ret);
    chk({tag, " pc"},        use3 ? pc3 : pc1, m_pc);
    chk({tag, " cop_error"}, use3 ? cop_error3 : cop_error1, m_err);
    for (int i = 0; i < 16; i++) begin
      dbg_raddr = 4'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), use3 ? dbg_rdata3 : dbg_rdata1, m_r[i]);
    end
    $display("run %s: cycles=%0d retired=%0d pc=0x%0h", tag, n, m_ret, m_pc);
  endtask

  initial begin
    int n;

    // Test 1: LDI/LDI/ADD/HALT
    clear_mem();
    mem[0] = 16'hA105; mem[1] = 16'hA2FD; mem[2] = 16'h0312;
    run_prog(0, 0, "t1");
    dbg_raddr = 4'd3; #1;
    chk("t1 r3 const", dbg_rdata1, 32'h2);
    chk("t1 retired const", retired1, 4);

    // Tests 2 and 3: more ALU ops, write to R0, MUL acked in 3rd req cycle
    clear_mem();
    mem[0] = 16'hA105; mem[1] = 16'hA2FD; mem[2] = 16'h0312; mem[3] = 16'h1421;
    mem[4] = 16'h5521; mem[5] = 16'h8621; mem[6] = 16'h0011; mem[7] = 16'h9711;
    run_prog(0, 3, "t2t3");
    dbg_raddr = 4'd4; #1; chk("t2 r4 const", dbg_rdata1, 32'hFFFFFFF8);
    dbg_raddr = 4'd6; #1; chk("t2 r6 const", dbg_rdata1, 32'hFFFFFFFF);
    dbg_raddr = 4'd7; #1; chk("t3 r7 const", dbg_rdata1, 32'h19);
    chk("t3 req length", last_len, 3);

    // Test 4: MUL never acked -> timeout, execution continues
    clear_mem();
    mem[0] = 16'hA105; mem[1] = 16'h9711; mem[2] = 16'hA801;
    run_prog(0, 0, "t4");
    chk("t4 req length", last_len, TMO);
    chk("t4 cop_error const", cop_error1, 1);

    // Test 5: taken BEQZ then JMP at IMEM_LAT=3
    clear_mem();
    mem[0] = 16'hB002; mem[3] = 16'hC010;
    fetch_cyc.delete();
    fetch_addr.delete();
    run_prog(1, 0, "t5");
    chk("t5 fetch count", fetch_addr.size(), 3);
    if (fetch_addr.size() == 3) begin
      chk("t5 fetch addr0", fetch_addr[0], 8'h00);
      chk("t5 fetch addr1", fetch_addr[1], 8'h03);
      chk("t5 fetch addr2", fetch_addr[2], 8'h10);
      chk("t5 spacing01", fetch_cyc[1] - fetch_cyc[0], 7);
      chk("t5 spacing12", fetch_cyc[2] - fetch_cyc[1], 7);
    end
    chk("t5 pulse width", wide3, 0);

    // Randomised programs against the reference model
    for (int r = 0; r < 6; r++) begin
      gen_random(r[0]);
      run_prog(0, (r == 5) ? 0 : int'($urandom_range(1, 6)), $sformatf("rand%0d", r));
    end

    // Test 6: reset while waiting on the coprocessor
    clear_mem();
    mem[0] = 16'hA105; mem[1] = 16'h9711;
    slave_delay = 0;
    @(negedge clock); rst1 = 1'b1;
    @(negedge clock); rst1 = 1'b0;
    n = 0;
    while (!cop_req1 && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("t6 req seen", cop_req1, 1);
    chk("t6 retired before", retired1, 1);
    @(posedge clock); #2;
    rst1 = 1'b1;
    #1;
    chk("t6 async cop_req", cop_req1, 0);
    chk("t6 pc", pc1, 0);
    chk("t6 retired", retired1, 0);
    @(negedge clock); rst1 = 1'b0;
    #1;
    chk("t6 refetch en", imem_en1, 1);
    chk("t6 refetch addr", imem_addr1, 0);
    $display("run t6: reset during coprocessor wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
